// File: rtl/aes_key_sched_iter.sv
// -----------------------------------------------------------------------------
// aes_key_sched_iter
//
// Iterative AES key-schedule engine for AES-128/192/256. It produces one 32-bit
// schedule word per clock and emits a 128-bit round key every fourth word, so
// consumers never need all Nr+1 round keys at once.
//
// Optional feature macro: AES_KEY_INV_EN
//   defined   : inv=1 runs the schedule backwards from the last Nk words down
//               to the cipher key (keys emitted Nr..0).
//   undefined : inv is ignored; every run is forward and the reverse
//               recurrence / descending counter are not built.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   single-cycle request, honoured only while busy=0
//   inv       in   direction sampled with start (0 forward, 1 inverse)
//   key       in   KEY_BITS key material, lowest-index word in the MSBs
//   busy      out  high from the accepting edge until the cycle after done
//   rk_valid  out  one-cycle strobe qualifying rk/rk_idx
//   rk_idx    out  round-key index j
//   rk        out  {w[4j], w[4j+1], w[4j+2], w[4j+3]}, w[4j] in [127:96]
//   done      out  pulse coincident with the last rk_valid of a run
//
// Also contains sbox, the single AES S-box used for SubWord.
// -----------------------------------------------------------------------------

module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Entry 0 sits in the MSBs; row r holds entries 16r..16r+15.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Bit offset of entry a is (255 - a) * 8.
  assign y = SBOX_TABLE[{~a, 3'b000} +: 8];
endmodule

module aes_key_sched_iter #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                inv,
  input  logic [KEY_BITS-1:0] key,
  output logic                busy,
  output logic                rk_valid,
  output logic [3:0]          rk_idx,
  output logic [127:0]        rk,
  output logic                done
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int TW = 4 * (NR + 1);
  localparam logic [5:0] LAST_CNT = 6'(TW - 1);
  localparam logic [5:0] NK_CNT   = 6'(NK);

  if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_key_bits_check
    $error("aes_key_sched_iter: KEY_BITS must be 128, 192 or 256");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [5:0]    cnt_reg, cnt_next;          // words produced so far in this run
  logic [31:0]   win_reg [NK];               // sliding window of the last Nk words
  logic [31:0]   win_next [NK];
  logic          rk_valid_reg, rk_valid_next;
  logic          done_reg, done_next;
  logic [3:0]    rk_idx_reg, rk_idx_next;
  logic [127:0]  rk_reg, rk_next;

`ifdef AES_KEY_INV_EN
  logic          dir_reg, dir_next;          // 1 = running the schedule backwards
  logic [5:0]    widx_reg, widx_next;        // schedule index i of the word being built
`else
  logic          inv_unused;
  assign inv_unused = inv;
`endif

  logic [31:0]   key_word [NK];
  logic [31:0]   temp_in;
  logic [31:0]   base_word;
  logic [6:0]    temp_idx;
  logic          emit;
  logic [3:0]    emit_idx;
  int            temp_phase;
  int            temp_round;
  logic [31:0]   sub_in;
  logic [31:0]   sub_out;
  logic [31:0]   temp_word;
  logic          key_phase;
  logic [31:0]   new_word;
  logic [127:0]  rk_word;

  function automatic logic [7:0] rcon_of(input int r);
    logic [7:0] rc;
    case (r)
      1:       rc = 8'h01;
      2:       rc = 8'h02;
      3:       rc = 8'h04;
      4:       rc = 8'h08;
      5:       rc = 8'h10;
      6:       rc = 8'h20;
      7:       rc = 8'h40;
      8:       rc = 8'h80;
      9:       rc = 8'h1b;
      10:      rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Split the key into words, word 0 from the MSBs.
  for (genvar gi = 0; gi < NK; gi++) begin : g_key_word
    assign key_word[gi] = key[KEY_BITS-1-32*gi -: 32];
  end

  // Operand selection. Forward: the window holds w[i-Nk..i-1] with the oldest
  // word in slot 0. Inverse: the window holds w[i+1..i+Nk] with the newest
  // (lowest index) word in slot 0, so w[i+Nk] is slot Nk-1 and the temp input
  // w[i+Nk-1] is slot Nk-2. During the first Nk words the window simply
  // rotates, replaying the loaded key words in generation order.
  always_comb begin
    temp_in   = win_reg[NK-1];
    base_word = win_reg[0];
    temp_idx  = {1'b0, cnt_reg};
    emit      = (cnt_reg[1:0] == 2'd3);
    emit_idx  = cnt_reg[5:2];
`ifdef AES_KEY_INV_EN
    if (dir_reg) begin
      temp_in   = win_reg[NK-2];
      base_word = win_reg[NK-1];
      temp_idx  = {1'b0, widx_reg} + 7'(NK);
      emit      = (widx_reg[1:0] == 2'd0);
      emit_idx  = widx_reg[5:2];
    end
`endif
  end

  // Position of the temp index inside its Nk-word group. Nk is a constant,
  // so these reduce to small fixed dividers.
  always_comb begin
    temp_phase = int'(temp_idx) % NK;
    temp_round = int'(temp_idx) / NK;
    sub_in     = (temp_phase == 0) ? {temp_in[23:0], temp_in[31:24]} : temp_in;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_subword
    sbox u_sbox (
      .a (sub_in[8*gi +: 8]),
      .y (sub_out[8*gi +: 8])
    );
  end

  always_comb begin
    temp_word = temp_in;
    if (temp_phase == 0) begin
      temp_word = sub_out ^ {rcon_of(temp_round), 24'h000000};
    end else if (NK == 8 && temp_phase == 4) begin
      temp_word = sub_out;
    end
  end

  assign key_phase = (cnt_reg < NK_CNT);
  assign new_word  = key_phase ? base_word : (base_word ^ temp_word);

  // Round key assembly keeps forward word order in both directions.
  always_comb begin
    rk_word = {win_reg[NK-3], win_reg[NK-2], win_reg[NK-1], new_word};
`ifdef AES_KEY_INV_EN
    if (dir_reg) begin
      rk_word = {new_word, win_reg[0], win_reg[1], win_reg[2]};
    end
`endif
  end

  // busy stays up through the done cycle even though the FSM is already IDLE.
  assign busy     = (state_reg == RUN) || done_reg;
  assign rk_valid = rk_valid_reg;
  assign done     = done_reg;
  assign rk_idx   = rk_idx_reg;
  assign rk       = rk_reg;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    win_next      = win_reg;
    rk_valid_next = 1'b0;
    done_next     = 1'b0;
    rk_idx_next   = rk_idx_reg;
    rk_next       = rk_reg;
`ifdef AES_KEY_INV_EN
    dir_next      = dir_reg;
    widx_next     = widx_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start && !busy) begin
          state_next = RUN;
          cnt_next   = '0;
          for (int m = 0; m < NK; m++) begin
            win_next[m] = key_word[m];
          end
`ifdef AES_KEY_INV_EN
          dir_next  = inv;
          widx_next = LAST_CNT;
`endif
        end
      end
      RUN: begin
        cnt_next = cnt_reg + 6'd1;
        for (int m = 0; m < NK - 1; m++) begin
          win_next[m] = win_reg[m+1];
        end
        win_next[NK-1] = new_word;
`ifdef AES_KEY_INV_EN
        widx_next = widx_reg - 6'd1;
        if (dir_reg) begin
          for (int m = 1; m < NK; m++) begin
            win_next[m] = win_reg[m-1];
          end
          win_next[0] = new_word;
        end
`endif
        if (emit) begin
          rk_valid_next = 1'b1;
          rk_idx_next   = emit_idx;
          rk_next       = rk_word;
        end
        if (cnt_reg == LAST_CNT) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      rk_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
      rk_idx_reg   <= '0;
      rk_reg       <= '0;
      for (int m = 0; m < NK; m++) begin
        win_reg[m] <= '0;
      end
`ifdef AES_KEY_INV_EN
      dir_reg      <= 1'b0;
      widx_reg     <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      rk_valid_reg <= rk_valid_next;
      done_reg     <= done_next;
      rk_idx_reg   <= rk_idx_next;
      rk_reg       <= rk_next;
      for (int m = 0; m < NK; m++) begin
        win_reg[m] <= win_next[m];
      end
`ifdef AES_KEY_INV_EN
      dir_reg      <= dir_next;
      widx_reg     <= widx_next;
`endif
    end
  end

endmodule

// File: tb/tb_aes_key_sched_iter.sv
// -----------------------------------------------------------------------------
// tb_aes_key_sched_iter
//
// Bench for aes_key_sched_iter with one instance per key size (128/192/256).
// Expected schedules come from a FIPS-197 style forward expansion whose S-box
// is derived from GF(2^8) inversion plus the affine map. Inverse runs (when
// AES_KEY_INV_EN is defined) are fed the last Nk words of a forward expansion
// and must return that schedule's round keys from Nr down to 0.
// -----------------------------------------------------------------------------

module tb_aes_key_sched_iter;
`ifdef AES_KEY_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   start_v;
  logic         inv;
  logic [255:0] key_v [3];
  logic [2:0]   busy_v, rk_valid_v, done_v;
  logic [3:0]   rk_idx_v [3];
  logic [127:0] rk_v [3];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]   sb_tab [256];
  logic [31:0]  ref_w [60];
  logic [127:0] exp_rk [15];
  logic [3:0]   exp_idx [15];
  logic [127:0] got_rk [16];

  typedef struct {
    int           sel;      // 0:128 1:192 2:256
    logic         inv;
    logic [255:0] cipher;   // cipher key, left aligned
    int           chk;      // round key index to compare
    logic [127:0] exp;
    int           glitch;   // cycle to pulse start mid-run, -1 none
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    aes_key_sched_iter #(.KEY_BITS(128 + 64*gi)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_v[gi]),
      .inv      (inv),
      .key      (key_v[gi][255 -: 128 + 64*gi]),
      .busy     (busy_v[gi]),
      .rk_valid (rk_valid_v[gi]),
      .rk_idx   (rk_idx_v[gi]),
      .rk       (rk_v[gi]),
      .done     (done_v[gi])
    );
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    return d[15-n -: 8];
  endfunction

  task automatic build_sbox();
    logic [7:0] x, y, b;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      b = 8'h00;
      for (int u = 1; u < 256; u++) begin
        y = 8'(u);
        if (x != 8'h00 && gmul(x, y) == 8'h01) b = y;
      end
      sb_tab[v] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
  endfunction

  // Forward expansion of a cipher key, then expected emission order and the
  // key the DUT must be given for the chosen direction.
  task automatic prep(input int sel, input logic inv_i, input logic [255:0] cipher,
                      output logic [255:0] dkey);
    int nk, nr, tw, j;
    logic [7:0] rc;
    logic [31:0] t;
    bit inv_eff;
    nk = 4 + 2*sel; nr = nk + 6; tw = 4*(nr + 1);
    inv_eff = INV_EN && inv_i;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) ref_w[i] = cipher[255-32*i -: 32];
    for (int i = nk; i < tw; i++) begin
      t = ref_w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw(t);
      end
      ref_w[i] = ref_w[i-nk] ^ t;
    end
    for (int n = 0; n <= nr; n++) begin
      j = inv_eff ? (nr - n) : n;
      exp_rk[n]  = {ref_w[4*j], ref_w[4*j+1], ref_w[4*j+2], ref_w[4*j+3]};
      exp_idx[n] = 4'(j);
    end
    dkey = '0;
    for (int m = 0; m < nk; m++)
      dkey[255-32*m -: 32] = inv_eff ? ref_w[tw-nk+m] : ref_w[m];
  endtask

  // One full run: start at the current negedge, then check every cycle until
  // the cycle after done. Called at a negedge.
  task automatic run(input int sel, input logic inv_i, input logic [255:0] dkey,
                     input int glitch, input string tag);
    int nk, nr, tw, n;
    bit exp_v;
    nk = 4 + 2*sel; nr = nk + 6; tw = 4*(nr + 1); n = 0;
    for (int m = 0; m < 16; m++) got_rk[m] = '0;
    key_v[sel] = dkey; inv = inv_i; start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
    chk({tag, " busy_at_accept"}, 128'(busy_v[sel]), 128'(1'b1));
    for (int cyc = 1; cyc <= tw + 1; cyc++) begin
      @(negedge clk);
      if (cyc == glitch + 1) begin
        start_v[sel] = 1'b0; key_v[sel] = dkey; inv = inv_i;
      end
      exp_v = (cyc >= 4) && (cyc % 4 == 0) && (cyc <= tw);
      chk($sformatf("%s busy c%0d", tag, cyc), 128'(busy_v[sel]), 128'(cyc <= tw));
      chk($sformatf("%s rk_valid c%0d", tag, cyc), 128'(rk_valid_v[sel]), 128'(exp_v));
      chk($sformatf("%s done c%0d", tag, cyc), 128'(done_v[sel]), 128'(cyc == tw));
      if (rk_valid_v[sel] && n <= nr) begin
        chk($sformatf("%s rk n%0d", tag, n), rk_v[sel], exp_rk[n]);
        chk($sformatf("%s rk_idx n%0d", tag, n), 128'(rk_idx_v[sel]), 128'(exp_idx[n]));
        got_rk[rk_idx_v[sel]] = rk_v[sel];
        n++;
      end else if (n > 0) begin
        chk($sformatf("%s rk_hold c%0d", tag, cyc), rk_v[sel], exp_rk[n-1]);
      end
      if (cyc == glitch) begin
        start_v[sel] = 1'b1; key_v[sel] = ~dkey; inv = ~inv_i;
      end
    end
    chk({tag, " key_count"}, 128'(n), 128'(nr + 1));
    $display("run %s: size=%0d inv=%0b keys=%0d last_rk=%h", tag, 128 + 64*sel, inv_i, n, rk_v[sel]);
  endtask

  initial begin
    logic [255:0] cipher, dkey;
    logic ri;
    rst_n = 1'b0; start_v = '0; inv = 1'b0;
    for (int s = 0; s < 3; s++) key_v[s] = '0;
    build_sbox();

    vecs.push_back('{0, 1'b0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 0,
                     128'h2b7e151628aed2a6abf7158809cf4f3c, -1});
    vecs.push_back('{0, 1'b0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1,
                     128'ha0fafe1788542cb123a339392a6c7605, -1});
    vecs.push_back('{0, 1'b0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 10,
                     128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 10});
    vecs.push_back('{1, 1'b0, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 12,
                     128'he98ba06f448c773c8ecc720401002202, -1});
    vecs.push_back('{2, 1'b0, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 14,
                     128'hfe4890d1e6188d0b046df344706c631e, 30});
`ifdef AES_KEY_INV_EN
    vecs.push_back('{0, 1'b1, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 0,
                     128'h2b7e151628aed2a6abf7158809cf4f3c, 17});
`endif

    // Reset state
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset busy%0d", s), 128'(busy_v[s]), 128'(1'b0));
      chk($sformatf("reset rk_valid%0d", s), 128'(rk_valid_v[s]), 128'(1'b0));
      chk($sformatf("reset done%0d", s), 128'(done_v[s]), 128'(1'b0));
      chk($sformatf("reset rk_idx%0d", s), 128'(rk_idx_v[s]), 128'(4'd0));
      chk($sformatf("reset rk%0d", s), rk_v[s], 128'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Known-answer table
    foreach (vecs[v]) begin
      prep(vecs[v].sel, vecs[v].inv, vecs[v].cipher, dkey);
      run(vecs[v].sel, vecs[v].inv, dkey, vecs[v].glitch, $sformatf("tbl%0d", v));
      chk($sformatf("tbl%0d rk[%0d]", v, vecs[v].chk), got_rk[vecs[v].chk], vecs[v].exp);
    end

    // Randomised keys and directions against the reference expansion
    for (int s = 0; s < 3; s++) begin
      for (int r = 0; r < 4; r++) begin
        cipher = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
        ri = 1'($urandom_range(0, 1));
        prep(s, ri, cipher, dkey);
        run(s, ri, dkey, -1, $sformatf("rnd_s%0d_r%0d", s, r));
      end
    end

    // Asynchronous reset in the middle of a run
    cipher = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
    key_v[0] = cipher; inv = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrun rk_valid_before_reset", 128'(rk_valid_v[0]), 128'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("midrun busy", 128'(busy_v[0]), 128'(1'b0));
    chk("midrun rk_valid", 128'(rk_valid_v[0]), 128'(1'b0));
    chk("midrun done", 128'(done_v[0]), 128'(1'b0));
    chk("midrun rk_idx", 128'(rk_idx_v[0]), 128'(4'd0));
    chk("midrun rk", rk_v[0], 128'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset done", 128'(done_v[0]), 128'(1'b0));
    prep(0, 1'b0, cipher, dkey);
    run(0, 1'b0, dkey, -1, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
